instr_packer: RTL and testbench

//  Inverse of immediate extension: takes a base instruction word plus a 32-bit signed immediate
//  and packs the immediate into the I/S/B/J field layout selected by immsrc.

---
 rtl/instr_packer_pkg.sv | 28 ++
 rtl/instr_packer_imm_pack.sv | 46 ++++
 rtl/instr_packer.sv | 102 ++++++++++
 tb/tb_instr_packer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_packer_pkg.sv
// Shared RISC-V immediate encodings and field positions, common to the packer and the immediate extender.
package instr_packer_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_t;

  localparam int I_IMM_LSB   = 20;
  localparam int S_HI_LSB    = 25;
  localparam int S_LO_LSB    = 7;
  localparam int B_BIT11_POS = 7;
  localparam int B_LO_LSB    = 8;
  localparam int J_BIT11_POS = 20;
  localparam int J_HI_LSB    = 21;

  // True when v[31:msb] are all copies of the sign bit, i.e. v fits in msb+1 signed bits.
  function automatic logic is_sext(input logic [31:0] v, input int msb);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 32; b++)
      if (b >= msb && v[b] != v[31]) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/instr_packer_imm_pack.sv
// Combinational packer: scatters a signed immediate into the I/S/B/J bit layout of a base word.
module imm_pack
  import instr_packer_pkg::*;
(
  input  logic [31:0] base,
  input  logic [31:0] imm,
  input  logic [1:0]  immsrc,
  output logic [31:0] instr,
  output logic        err
);

  immsrc_t sel;
  assign sel = immsrc_t'(immsrc);

  always_comb begin
    instr = base;
    err   = 1'b0;
    case (sel)
      IMM_I: begin
        instr[31:I_IMM_LSB] = imm[11:0];
        err                 = !is_sext(imm, 11);
      end
      IMM_S: begin
        instr[31:S_HI_LSB]   = imm[11:5];
        instr[S_LO_LSB +: 5] = imm[4:0];
        err                  = !is_sext(imm, 11);
      end
      IMM_B: begin
        instr[31]            = imm[12];
        instr[B_BIT11_POS]   = imm[11];
        instr[30:S_HI_LSB]   = imm[10:5];
        instr[B_LO_LSB +: 4] = imm[4:1];
        err                  = !is_sext(imm, 12) || imm[0];
      end
      IMM_J: begin
        instr[31]          = imm[20];
        instr[19:12]       = imm[19:12];
        instr[J_BIT11_POS] = imm[11];
        instr[30:J_HI_LSB] = imm[10:1];
        err                = !is_sext(imm, 20) || imm[0];
      end
      default: instr = base;
    endcase
  end

endmodule

// File: rtl/instr_packer.sv
// Instruction packer: packs immediates into base words, tags word addresses, and streams
// results through a 2-entry FIFO with delivery counters and a sticky error flag.
module instr_packer
  import instr_packer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       immsrc,
  input  logic [31:0]      base,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_addr,
  output logic             out_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [31:0] pk_instr_p0;
  logic        pk_err_p0;
  logic [31:0] instr_p1 [2];
  logic [31:0] addr_p1  [2];
  logic [1:0]  err_p1;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fill;
  logic [31:0] next_addr;
  logic        push;
  logic        pop;

  imm_pack u_pack (
    .base   (base),
    .imm    (imm),
    .immsrc (immsrc),
    .instr  (pk_instr_p0),
    .err    (pk_err_p0)
  );

  // p0 -> p1: packed word enters the buffer; outputs always present the oldest entry
  assign in_ready  = (fill != 2'd2) && !clr;
  assign push      = in_valid && in_ready;
  assign out_valid = (fill != 2'd0);
  assign pop       = out_valid && out_ready && !clr;
  assign out_instr = instr_p1[rd_ptr];
  assign out_addr  = addr_p1[rd_ptr];
  assign out_err   = err_p1[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_p1[0] <= '0;
      instr_p1[1] <= '0;
      addr_p1[0]  <= '0;
      addr_p1[1]  <= '0;
      err_p1      <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fill        <= 2'd0;
      next_addr   <= BASE_ADDR;
      err_sticky  <= 1'b0;
      word_cnt    <= '0;
      err_cnt     <= '0;
    end else if (clr) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fill       <= 2'd0;
      next_addr  <= BASE_ADDR;
      err_sticky <= 1'b0;
      word_cnt   <= '0;
      err_cnt    <= '0;
    end else begin
      if (push) begin
        instr_p1[wr_ptr] <= pk_instr_p0;
        addr_p1[wr_ptr]  <= next_addr;
        err_p1[wr_ptr]   <= pk_err_p0;
        wr_ptr           <= !wr_ptr;
        next_addr        <= next_addr + 32'd4;
      end
      if (pop) begin
        rd_ptr   <= !rd_ptr;
        word_cnt <= sat_inc(word_cnt);
        if (out_err) begin
          err_cnt    <= sat_inc(err_cnt);
          err_sticky <= 1'b1;
        end
      end
      fill <= fill + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_instr_packer.sv
// Bench for instr_packer: directed steps plus randomized traffic against a queue-based reference model.
module tb_instr_packer;

  logic        clk = 1'b0;
  logic        reset, clr, in_valid, out_ready;
  logic        in_ready, out_valid, out_err, err_sticky;
  logic [1:0]  immsrc;
  logic [31:0] base, imm, out_instr, out_addr;
  logic [15:0] word_cnt, err_cnt;

  logic        clr2, in_valid2, out_ready2;
  logic        in_ready2, out_valid2, out_err2, err_sticky2;
  logic [31:0] out_instr2, out_addr2;
  logic [15:0] word_cnt2, err_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_packer #(.BASE_ADDR(32'h0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .immsrc(immsrc), .base(base), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky),
    .word_cnt(word_cnt), .err_cnt(err_cnt)
  );

  instr_packer #(.BASE_ADDR(32'hFFFF_FFFC), .CNT_W(16)) dut2 (
    .clk(clk), .reset(reset), .clr(clr2), .in_valid(in_valid2), .in_ready(in_ready2),
    .immsrc(immsrc), .base(base), .imm(imm), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_instr(out_instr2), .out_addr(out_addr2), .out_err(out_err2), .err_sticky(err_sticky2),
    .word_cnt(word_cnt2), .err_cnt(err_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V field layout written as whole-word concatenations.
  function automatic logic [31:0] ref_pack(input logic [1:0] s, input logic [31:0] b, input logic [31:0] i);
    case (s)
      2'd0:    return {i[11:0], b[19:0]};
      2'd1:    return {i[11:5], b[24:12], i[4:0], b[6:0]};
      2'd2:    return {i[12], i[10:5], b[24:12], i[4:1], i[11], b[6:0]};
      default: return {i[20], i[10:1], i[11], i[19:12], b[11:0]};
    endcase
  endfunction

  // Reference: error means the signed value is outside the field's range or is odd for B/J.
  function automatic logic ref_err(input logic [1:0] s, input logic [31:0] i);
    int v;
    v = $signed(i);
    case (s)
      2'd0, 2'd1: return (v < -2048) || (v > 2047);
      2'd2:       return (v < -4096) || (v > 4095) || i[0];
      default:    return (v < -1048576) || (v > 1048575) || i[0];
    endcase
  endfunction

  // Immediate extender, used for round-trip checks.
  function automatic logic [31:0] ext(input logic [1:0] s, input logic [31:0] x);
    case (s)
      2'd0:    return {{20{x[31]}}, x[31:20]};
      2'd1:    return {{20{x[31]}}, x[31:25], x[11:7]};
      2'd2:    return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
      default: return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
    endcase
  endfunction

  function automatic logic [31:0] rand_imm(input logic [1:0] s);
    int w;
    int t;
    if ($urandom_range(0, 7) == 0) return $urandom;
    w = $urandom_range(2, 23);
    t = int'($urandom) <<< (32 - w);
    t = t >>> (32 - w);
    if (s[1] && $urandom_range(0, 3) != 0) t = t & ~1;
    return 32'(t);
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
    logic [1:0]  src;
    logic [31:0] imm;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wc = 32'h0;
  logic [31:0] m_ec = 32'h0;
  logic        m_sticky = 1'b0;
  logic        m_acc, m_pop;

  // Model runs between edges: check current state, then apply the upcoming edge's handshakes.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      m_addr = 32'h0; m_wc = 32'h0; m_ec = 32'h0; m_sticky = 1'b0;
    end else begin
      chk1("in_ready", in_ready, (q.size() < 2) && !clr);
      chk1("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("out_instr", out_instr, q[0].instr);
        chk("out_addr", out_addr, q[0].addr);
        chk1("out_err", out_err, q[0].err);
      end
      chk("word_cnt", 32'(word_cnt), m_wc);
      chk("err_cnt", 32'(err_cnt), m_ec);
      chk1("err_sticky", err_sticky, m_sticky);
      if (clr) begin
        q.delete();
        m_addr = 32'h0; m_wc = 32'h0; m_ec = 32'h0; m_sticky = 1'b0;
      end else begin
        m_acc = in_valid && (q.size() < 2);
        m_pop = out_ready && (q.size() != 0);
        if (m_pop) begin
          e = q.pop_front();
          if (!e.err) chk("roundtrip", ext(e.src, out_instr), e.imm);
          if (m_wc != 32'hFFFF) m_wc = m_wc + 32'd1;
          if (e.err) begin
            if (m_ec != 32'hFFFF) m_ec = m_ec + 32'd1;
            m_sticky = 1'b1;
          end
        end
        if (m_acc) begin
          e.instr = ref_pack(immsrc, base, imm);
          e.addr  = m_addr;
          e.err   = ref_err(immsrc, imm);
          e.src   = immsrc;
          e.imm   = imm;
          q.push_back(e);
          m_addr = m_addr + 32'd4;
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [31:0] b, input logic [31:0] i);
    int n;
    n = 0;
    immsrc = s; base = b; imm = i; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      nxt();
      n++;
    end
    chk1("send_ready", in_ready, 1'b1);
    nxt();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    immsrc = 2'd0; base = 32'h0; imm = 32'h0;
    clr2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0;

    nxt();
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk1("rst_sticky", err_sticky, 1'b0);
    nxt();
    reset = 1'b0;

    // Address wrap on the second instance
    in_valid2 = 1'b1;
    nxt();
    nxt();
    in_valid2 = 1'b0;
    chk1("wrap_full", in_ready2, 1'b0);
    chk("wrap_addr0", out_addr2, 32'hFFFF_FFFC);
    out_ready2 = 1'b1;
    nxt();
    chk("wrap_addr1", out_addr2, 32'h0);
    chk1("wrap_valid", out_valid2, 1'b1);
    nxt();
    chk1("wrap_empty", out_valid2, 1'b0);
    chk("wrap_cnt", 32'(word_cnt2), 32'd2);

    // Directed packing
    send(2'd0, 32'h0000_0093, 32'hFFFF_F800);
    @(negedge clk);
    chk("i_instr", out_instr, 32'h8000_0093);
    chk1("i_err", out_err, 1'b0);
    chk("i_addr", out_addr, 32'h0);
    nxt();
    send(2'd1, 32'h0000_2023, 32'h0000_07FF);
    @(negedge clk);
    chk("s_instr", out_instr, 32'h7E00_2FA3);
    chk("s_addr", out_addr, 32'h4);
    nxt();
    send(2'd2, 32'h0000_0063, 32'hFFFF_FFFE);
    @(negedge clk);
    chk("b_instr", out_instr, 32'hFE00_0FE3);
    chk("b_addr", out_addr, 32'h8);
    nxt();
    send(2'd3, 32'h0000_006F, 32'h0000_0800);
    @(negedge clk);
    chk("j_instr", out_instr, 32'h0010_006F);
    chk1("j_err", out_err, 1'b0);
    nxt();

    // Errors and sticky flag
    send(2'd0, 32'h0000_0093, 32'h0000_0800);
    @(negedge clk);
    chk("ierr_instr", out_instr, 32'h8000_0093);
    chk1("ierr_err", out_err, 1'b1);
    nxt();
    @(negedge clk);
    chk1("ierr_sticky", err_sticky, 1'b1);
    chk("ierr_cnt", 32'(err_cnt), 32'd1);
    nxt();
    send(2'd2, 32'h0000_0063, 32'h0000_0005);
    @(negedge clk);
    chk1("berr_err", out_err, 1'b1);
    nxt();
    send(2'd0, 32'h0000_0013, 32'h0000_0005);
    @(negedge clk);
    nxt();
    @(negedge clk);
    chk1("sticky_hold", err_sticky, 1'b1);
    chk("err_cnt2", 32'(err_cnt), 32'd2);
    chk("word_cnt7", 32'(word_cnt), 32'd7);
    nxt();

    // Backpressure
    out_ready = 1'b0;
    immsrc = 2'd0; base = 32'h13; imm = 32'd1; in_valid = 1'b1;
    nxt();
    imm = 32'd2;
    nxt();
    imm = 32'd3;
    chk1("bp_full", in_ready, 1'b0);
    chk("bp_head", out_addr, 32'h1C);
    repeat (3) nxt();
    chk("bp_stable", out_instr, 32'h0010_0013);
    chk1("bp_still_full", in_ready, 1'b0);
    out_ready = 1'b1;
    nxt();
    chk("bp_second", out_addr, 32'h20);
    nxt();
    in_valid = 1'b0;
    chk("bp_third_addr", out_addr, 32'h24);
    chk("bp_third_instr", out_instr, 32'h0030_0013);
    nxt();
    chk1("bp_drained", out_valid, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      immsrc    = 2'($urandom_range(0, 3));
      base      = $urandom;
      imm       = rand_imm(immsrc);
      out_ready = ($urandom_range(0, 3) != 0);
      nxt();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) nxt();

    // clr with a full buffer and a pending request
    out_ready = 1'b0;
    immsrc = 2'd0; base = 32'h93; imm = 32'd5; in_valid = 1'b1;
    nxt();
    nxt();
    chk1("clr_full", in_ready, 1'b0);
    clr = 1'b1;
    nxt();
    clr = 1'b0;
    in_valid = 1'b0;
    chk1("clr_valid", out_valid, 1'b0);
    chk("clr_wcnt", 32'(word_cnt), 32'd0);
    chk("clr_ecnt", 32'(err_cnt), 32'd0);
    chk1("clr_sticky", err_sticky, 1'b0);
    send(2'd0, 32'h93, 32'h0);
    @(negedge clk);
    chk("clr_addr", out_addr, 32'h0);
    nxt();
    out_ready = 1'b1;
    nxt();

    // Asynchronous reset mid-burst
    out_ready = 1'b0;
    immsrc = 2'd0; base = 32'h93; imm = 32'd7; in_valid = 1'b1;
    nxt();
    nxt();
    in_valid = 1'b0;
    chk1("ar_before", out_valid, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk1("ar_valid", out_valid, 1'b0);
    chk("ar_instr", out_instr, 32'h0);
    chk("ar_addr", out_addr, 32'h0);
    chk("ar_wcnt", 32'(word_cnt), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    nxt();
    chk1("ar_ready", in_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
